// File: rtl/sha_stream_host.sv
// Initiator-side controller for the sha core: gathers an Nl-byte message from a byte stream,
// pulses the core's Enable, captures the digest and streams it out MSB byte first.
module sha_stream_host #(
    parameter int Nl = 64,
    parameter int Nk = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    In_Data,
    input  logic          In_Valid,
    output logic          In_Ready,
    output logic [7:0]    Sha_Data [Nl],
    output logic          Sha_Enable,
    input  logic [Nk-1:0] Sha_Hash,
    input  logic          Sha_Ready,
    output logic [7:0]    Out_Data,
    output logic          Out_Valid,
    input  logic          Out_Ready,
    output logic          Out_Last,
    output logic          Busy
);
    localparam int NB = Nk / 8;
    localparam int CW = $clog2(Nl + 1);
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {LOAD, START, WAIT_HASH, SEND} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic [Nk-1:0]   r_hash;
    logic            w_in_fire;
    logic            w_out_fire;

    // Valid/ready: a byte moves on any rising edge where both are high; the source keeps
    // data stable while valid is high and not ready. Ready never depends on valid here.
    assign In_Ready   = (r_state == LOAD) && rst;
    assign w_in_fire  = In_Valid && In_Ready;
    assign w_out_fire = Out_Valid && Out_Ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= LOAD;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_hash     <= '0;
            Sha_Enable <= 1'b0;
            Out_Data   <= '0;
            Out_Valid  <= 1'b0;
            Out_Last   <= 1'b0;
            Busy       <= 1'b0;
            for (int i = 0; i < Nl; i++) Sha_Data[i] <= '0;
        end else begin
            Sha_Enable <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_in_fire) begin
                        for (int i = 0; i < Nl; i++) begin
                            if (r_cnt == CW'(i)) Sha_Data[i] <= In_Data;
                        end
                        if (r_cnt == CW'(Nl - 1)) begin
                            r_cnt      <= '0;
                            r_state    <= START;
                            Sha_Enable <= 1'b1;
                            Busy       <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                START: begin
                    r_state <= WAIT_HASH;
                end
                WAIT_HASH: begin
                    if (Sha_Ready) begin
                        r_hash    <= Sha_Hash;
                        r_idx     <= '0;
                        Out_Data  <= Sha_Hash[Nk-1 -: 8];
                        Out_Valid <= 1'b1;
                        Out_Last  <= (NB == 1);
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    if (w_out_fire) begin
                        if (r_idx == IW'(NB - 1)) begin
                            Out_Valid <= 1'b0;
                            Out_Last  <= 1'b0;
                            Out_Data  <= '0;
                            Busy      <= 1'b0;
                            r_state   <= LOAD;
                        end else begin
                            // r_hash is kept left-aligned so the next byte is always at the top.
                            r_hash   <= r_hash << 8;
                            Out_Data <= r_hash[Nk-9 -: 8];
                            Out_Last <= (r_idx == IW'(NB - 2));
                            r_idx    <= r_idx + IW'(1);
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_sha_stream_host.sv
// Directed bench for sha_stream_host: a stub sha answers Enable with chosen digests while
// byte streams go in and digests are drained under several back-pressure patterns.
module tb_sha_stream_host;
    localparam int NL   = 3;
    localparam int NK   = 256;
    localparam int NL_B = 4;
    localparam int NK_B = 160;
    localparam logic [255:0] H_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    // Arbitrary digest the stub returns for "abd".
    localparam logic [255:0] H_ABD =
        256'h5f3a9c1e_2b7d4086_a1c3e5f7_092b4d6f_8a0c2e4f_6a8b0d1f_3e5c7a9b_1d3f5e70;
    localparam logic [159:0] H_B = 160'h01234567_89abcdef_fedcba98_76543210_0f1e2d3c;

    logic           clk;
    logic           rst;
    logic [7:0]     In_Data;
    logic           In_Valid;
    logic           In_Ready;
    logic [7:0]     Sha_Data [NL];
    logic           Sha_Enable;
    logic [NK-1:0]  Sha_Hash;
    logic           Sha_Ready;
    logic [7:0]     Out_Data;
    logic           Out_Valid;
    logic           Out_Ready;
    logic           Out_Last;
    logic           Busy;

    logic [7:0]     b_In_Data;
    logic           b_In_Valid;
    logic           b_In_Ready;
    logic [7:0]     b_Sha_Data [NL_B];
    logic           b_Sha_Enable;
    logic [NK_B-1:0] b_Sha_Hash;
    logic           b_Sha_Ready;
    logic [7:0]     b_Out_Data;
    logic           b_Out_Valid;
    logic           b_Out_Ready;
    logic           b_Out_Last;
    logic           b_Busy;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    sha_stream_host #(.Nl(NL), .Nk(NK)) dut (
        .clk(clk), .rst(rst), .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Sha_Data(Sha_Data), .Sha_Enable(Sha_Enable), .Sha_Hash(Sha_Hash),
        .Sha_Ready(Sha_Ready), .Out_Data(Out_Data), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready), .Out_Last(Out_Last), .Busy(Busy)
    );

    sha_stream_host #(.Nl(NL_B), .Nk(NK_B)) dut_b (
        .clk(clk), .rst(rst), .In_Data(b_In_Data), .In_Valid(b_In_Valid),
        .In_Ready(b_In_Ready), .Sha_Data(b_Sha_Data), .Sha_Enable(b_Sha_Enable),
        .Sha_Hash(b_Sha_Hash), .Sha_Ready(b_Sha_Ready), .Out_Data(b_Out_Data),
        .Out_Valid(b_Out_Valid), .Out_Ready(b_Out_Ready), .Out_Last(b_Out_Last),
        .Busy(b_Busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (Sha_Enable === 1'b1) en_cnt++;

    // Drivers (all called at a falling edge, return at a falling edge)
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        In_Data  = b;
        In_Valid = 1'b1;
        while (In_Ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: In_Ready=%b required 1", In_Ready);
        end
        @(negedge clk);
        In_Valid = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] m0, m1, m2);
        send_byte(m0);
        send_byte(m1);
        send_byte(m2);
        checks++;
        if (Sha_Enable !== 1'b1) begin
            errors++;
            $display("FAIL enable_latency: Sha_Enable=%b required 1", Sha_Enable);
        end
    endtask

    task automatic sha_respond(input logic [7:0] m0, m1, m2, input logic [255:0] h,
                               input int delay);
        int t = 0;
        while (Sha_Enable !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL enable_timeout: Sha_Enable=%b required 1", Sha_Enable);
        end
        checks++;
        if (Sha_Data[0] !== m0 || Sha_Data[1] !== m1 || Sha_Data[2] !== m2) begin
            errors++;
            $display("FAIL sha_data: got %h %h %h required %h %h %h",
                     Sha_Data[0], Sha_Data[1], Sha_Data[2], m0, m1, m2);
        end
        checks++;
        if (Busy !== 1'b1 || In_Ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_start: Busy=%b In_Ready=%b required 1 0", Busy, In_Ready);
        end
        @(negedge clk);
        checks++;
        if (Sha_Enable !== 1'b0) begin
            errors++;
            $display("FAIL enable_width: Sha_Enable=%b required 0", Sha_Enable);
        end
        repeat (delay) @(negedge clk);
        checks++;
        if (Out_Valid !== 1'b0 || Sha_Data[0] !== m0 || Sha_Data[2] !== m2) begin
            errors++;
            $display("FAIL wait_hold: Out_Valid=%b data0=%h data2=%h required 0 %h %h",
                     Out_Valid, Sha_Data[0], Sha_Data[2], m0, m2);
        end
        Sha_Hash  = h;
        Sha_Ready = 1'b1;
        @(negedge clk);
        Sha_Ready = 1'b0;
        Sha_Hash  = {8{32'hdeadbeef}};
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic recv_digest(input logic [255:0] h, input int mode, input int nbytes);
        logic [7:0] exp_q[$];
        int idx = 0;
        int k = 0;
        int t;
        logic rdy;
        for (int i = 0; i < 32; i++) exp_q.push_back(h[255-8*i -: 8]);
        while (idx < nbytes) begin
            t = 0;
            while (Out_Valid !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) begin
                checks++; errors++;
                $display("FAIL out_valid_timeout: byte %0d Out_Valid=%b required 1", idx, Out_Valid);
                Out_Ready = 1'b0;
                return;
            end
            checks++;
            if (Out_Data !== exp_q[0]) begin
                errors++;
                $display("FAIL out_data[%0d]: got %h required %h", idx, Out_Data, exp_q[0]);
            end
            checks++;
            if (Out_Last !== (idx == 31)) begin
                errors++;
                $display("FAIL out_last[%0d]: got %b required %b", idx, Out_Last, idx == 31);
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = ((k % 4) == 0) || ((k % 4) == 3);
            else                rdy = 1'($urandom_range(0, 1));
            k++;
            Out_Ready = rdy;
            @(negedge clk);
            if (rdy) begin
                void'(exp_q.pop_front());
                idx++;
            end
        end
        Out_Ready = 1'b0;
        if (nbytes == 32) begin
            checks++;
            if (Out_Valid !== 1'b0 || In_Ready !== 1'b1 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_digest: Out_Valid=%b In_Ready=%b Busy=%b required 0 1 0",
                         Out_Valid, In_Ready, Busy);
            end
        end
    endtask

    // Tests
    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (In_Ready !== 1'b0 || Busy !== 1'b0 || Out_Valid !== 1'b0 || Out_Last !== 1'b0 ||
            Out_Data !== 8'h00 || Sha_Enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: InR=%b Busy=%b OV=%b OL=%b OD=%h En=%b required all 0",
                     In_Ready, Busy, Out_Valid, Out_Last, Out_Data, Sha_Enable);
        end
        checks++;
        if (Sha_Data[0] !== 8'h00 || Sha_Data[1] !== 8'h00 || Sha_Data[2] !== 8'h00) begin
            errors++;
            $display("FAIL reset_sha_data: got %h %h %h required 00 00 00",
                     Sha_Data[0], Sha_Data[1], Sha_Data[2]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (In_Ready !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: In_Ready=%b Busy=%b required 1 0", In_Ready, Busy);
        end
    endtask

    task automatic test_single_abc();
        int en0 = en_cnt;
        send_msg(8'h61, 8'h62, 8'h63);
        sha_respond(8'h61, 8'h62, 8'h63, H_ABC, 4);
        recv_digest(H_ABC, 0, 32);
        checks++;
        if (en_cnt - en0 !== 1) begin
            errors++;
            $display("FAIL enable_count_single: got %0d required 1", en_cnt - en0);
        end
    endtask

    task automatic test_backpressure();
        send_msg(8'h61, 8'h62, 8'h63);
        sha_respond(8'h61, 8'h62, 8'h63, H_ABC, 2);
        recv_digest(H_ABC, 1, 32);
    endtask

    task automatic test_gaps_nl4();
        logic [7:0] bytes [4];
        int pat [6];
        int k = 0;
        int t = 0;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        pat = '{1, 0, 1, 1, 0, 1};
        for (int i = 0; i < 6; i++) begin
            if (pat[i] == 1) begin
                b_In_Data  = bytes[k];
                b_In_Valid = 1'b1;
                checks++;
                if (b_In_Ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b_in_ready[%0d]: got %b required 1", k, b_In_Ready);
                end
                k++;
            end else begin
                b_In_Data  = 8'hee;
                b_In_Valid = 1'b0;
            end
            @(negedge clk);
        end
        b_In_Data  = 8'h55;
        b_In_Valid = 1'b1;
        checks++;
        if (b_Sha_Enable !== 1'b1 || b_Busy !== 1'b1) begin
            errors++;
            $display("FAIL b_enable_latency: En=%b Busy=%b required 1 1", b_Sha_Enable, b_Busy);
        end
        checks++;
        if (b_Sha_Data[0] !== 8'h11 || b_Sha_Data[1] !== 8'h22 ||
            b_Sha_Data[2] !== 8'h33 || b_Sha_Data[3] !== 8'h44) begin
            errors++;
            $display("FAIL b_sha_data: got %h %h %h %h required 11 22 33 44",
                     b_Sha_Data[0], b_Sha_Data[1], b_Sha_Data[2], b_Sha_Data[3]);
        end
        @(negedge clk);
        checks++;
        if (b_Sha_Enable !== 1'b0 || b_In_Ready !== 1'b0) begin
            errors++;
            $display("FAIL b_enable_width: En=%b In_Ready=%b required 0 0", b_Sha_Enable, b_In_Ready);
        end
        repeat (3) @(negedge clk);
        b_Sha_Hash  = H_B;
        b_Sha_Ready = 1'b1;
        @(negedge clk);
        b_Sha_Ready = 1'b0;
        b_Sha_Hash  = '0;
        b_In_Valid  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            t = 0;
            while (b_Out_Valid !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (b_Out_Data !== H_B[159-8*i -: 8] || b_Out_Last !== (i == 19) ||
                b_In_Ready !== 1'b0) begin
                errors++;
                $display("FAIL b_out[%0d]: data=%h last=%b inr=%b required %h %b 0",
                         i, b_Out_Data, b_Out_Last, b_In_Ready, H_B[159-8*i -: 8], i == 19);
            end
            b_Out_Ready = 1'b1;
            @(negedge clk);
            b_Out_Ready = 1'b0;
        end
        checks++;
        if (b_Out_Valid !== 1'b0 || b_In_Ready !== 1'b1 || b_Sha_Data[0] !== 8'h11) begin
            errors++;
            $display("FAIL b_done: OV=%b InR=%b data0=%h required 0 1 11",
                     b_Out_Valid, b_In_Ready, b_Sha_Data[0]);
        end
    endtask

    task automatic test_spurious_ready();
        Sha_Hash  = H_ABC;
        Sha_Ready = 1'b1;
        @(negedge clk);
        Sha_Ready = 1'b0;
        @(negedge clk);
        checks++;
        if (Out_Valid !== 1'b0 || Busy !== 1'b0 || In_Ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_in_load: OV=%b Busy=%b InR=%b required 0 0 1",
                     Out_Valid, Busy, In_Ready);
        end
        send_msg(8'h61, 8'h62, 8'h63);
        sha_respond(8'h61, 8'h62, 8'h63, 256'h1, 1);
        Sha_Hash  = H_ABC;
        Sha_Ready = 1'b1;
        @(negedge clk);
        Sha_Ready = 1'b0;
        recv_digest(256'h1, 0, 32);
    endtask

    task automatic test_reset_midop();
        int en0;
        send_msg(8'h61, 8'h62, 8'h63);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (In_Ready !== 1'b0 || Busy !== 1'b0 || Out_Valid !== 1'b0 || Sha_Enable !== 1'b0 ||
            Sha_Data[0] !== 8'h00) begin
            errors++;
            $display("FAIL reset_in_wait: InR=%b Busy=%b OV=%b En=%b data0=%h required 0 0 0 0 00",
                     In_Ready, Busy, Out_Valid, Sha_Enable, Sha_Data[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0 || In_Ready !== 1'b1) begin
            errors++;
            $display("FAIL release_after_wait: Busy=%b InR=%b required 0 1", Busy, In_Ready);
        end
        Sha_Hash  = H_ABC;
        Sha_Ready = 1'b1;
        @(negedge clk);
        Sha_Ready = 1'b0;
        @(negedge clk);
        checks++;
        if (Out_Valid !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL late_ready: OV=%b Busy=%b required 0 0", Out_Valid, Busy);
        end
        en0 = en_cnt;
        send_byte(8'h78);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (en_cnt !== en0) begin
            errors++;
            $display("FAIL partial_enable: count delta %0d required 0", en_cnt - en0);
        end
        send_msg(8'h61, 8'h62, 8'h63);
        sha_respond(8'h61, 8'h62, 8'h63, H_ABC, 1);
        recv_digest(H_ABC, 0, 5);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (Out_Valid !== 1'b0 || Out_Data !== 8'h00 || Out_Last !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_send: OV=%b OD=%h OL=%b Busy=%b required 0 00 0 0",
                     Out_Valid, Out_Data, Out_Last, Busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (In_Ready !== 1'b1 || Out_Valid !== 1'b0) begin
            errors++;
            $display("FAIL release_after_send: InR=%b OV=%b required 1 0", In_Ready, Out_Valid);
        end
        send_msg(8'h61, 8'h62, 8'h63);
        sha_respond(8'h61, 8'h62, 8'h63, H_ABC, 2);
        recv_digest(H_ABC, 0, 32);
    endtask

    task automatic test_back_to_back();
        int en0 = en_cnt;
        send_msg(8'h61, 8'h62, 8'h63);
        sha_respond(8'h61, 8'h62, 8'h63, H_ABC, 3);
        recv_digest(H_ABC, 0, 32);
        send_msg(8'h61, 8'h62, 8'h64);
        sha_respond(8'h61, 8'h62, 8'h64, H_ABD, 3);
        recv_digest(H_ABD, 2, 32);
        checks++;
        if (en_cnt - en0 !== 2) begin
            errors++;
            $display("FAIL enable_count_b2b: got %0d required 2", en_cnt - en0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        In_Data     = '0;
        In_Valid    = 1'b0;
        Sha_Hash    = '0;
        Sha_Ready   = 1'b0;
        Out_Ready   = 1'b0;
        b_In_Data   = '0;
        b_In_Valid  = 1'b0;
        b_Sha_Hash  = '0;
        b_Sha_Ready = 1'b0;
        b_Out_Ready = 1'b0;
        #1 rst = 1'b0;
        test_reset();
        test_single_abc();
        test_backpressure();
        test_gaps_nl4();
        test_spurious_ready();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
